// File: rtl/mul_slice_accumulator.sv
// mul_slice_accumulator: shift-accumulates NUM_SLICES byte-slice partial products
// into a full unsigned A_W x (SLICE_W*NUM_SLICES) product behind a valid/ready output.
module mul_slice_accumulator #(
    parameter int A_W        = 32,
    parameter int SLICE_W    = 8,
    parameter int NUM_SLICES = 4,
    parameter int PP_W       = A_W + SLICE_W,
    parameter int OUT_W      = A_W + SLICE_W * NUM_SLICES
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [PP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             err_seq
);
    localparam int CW = $clog2(NUM_SLICES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] sum;

    assign in_ready = nrst & (state != DONE);
    assign ext      = OUT_W'(in_data);
    assign sum      = acc + (ext << (SLICE_W * cnt));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_seq   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (!in_first) begin
                        err_seq <= 1'b1;
                    end else if (NUM_SLICES == 1) begin
                        acc       <= ext;
                        out_data  <= ext;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= ext;
                        cnt   <= CW'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: if (in_valid) begin
                    if (in_first) begin
                        // A fresh slice 0 abandons the partial product in flight
                        acc     <= ext;
                        cnt     <= CW'(1);
                        err_seq <= 1'b1;
                    end else if (cnt == LAST) begin
                        acc       <= sum;
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
